// File: rtl/alu_pipe_cc.sv
// rtl/alu_pipe_cc.sv - pipelined ADD/SUB/AND/XOR ALU with valid/ready flow control and CC register
module alu_pipe_cc #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam int MSB = WIDTH - 1;
    localparam int LST = LATENCY - 1;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] ovf_q;
    logic [LATENCY-1:0] scc_q;
    logic [WIDTH-1:0]   res_q [LATENCY];
    logic [LATENCY-1:0] load;

    logic [WIDTH-1:0]   alu_r;
    logic               alu_ovf;

    logic               zf_q, sf_q, of_q;
    logic               zf_d, sf_d, of_d;
    logic               retire;

    always_comb begin
        alu_r   = '0;
        alu_ovf = 1'b0;
        case (ctrl)
            2'd0: begin
                alu_r   = a + b;
                alu_ovf = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            2'd1: begin
                alu_r   = a - b;
                alu_ovf = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            2'd2:    alu_r = a & b;
            default: alu_r = a ^ b;
        endcase
    end

    // A stage loads when empty or when its successor drains it; an empty stage
    // anywhere downstream therefore lets everything upstream advance.
    always_comb begin
        logic nxt;
        load      = '0;
        nxt       = !vld_q[LST] || out_ready;
        load[LST] = nxt;
        for (int k = LST - 1; k >= 0; k--) begin
            nxt     = !vld_q[k] || nxt;
            load[k] = nxt;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[LST];
    assign result    = res_q[LST];
    assign overflow  = ovf_q[LST];
    assign retire    = vld_q[LST] && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ovf_q <= '0;
            scc_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (load[k]) begin
                    if (k == 0) begin
                        vld_q[0] <= in_valid;
                        res_q[0] <= alu_r;
                        ovf_q[0] <= alu_ovf;
                        scc_q[0] <= set_cc;
                    end else begin
                        vld_q[k] <= vld_q[k-1];
                        res_q[k] <= res_q[k-1];
                        ovf_q[k] <= ovf_q[k-1];
                        scc_q[k] <= scc_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (retire && scc_q[LST]) begin
            zf_d = (res_q[LST] == '0);
            sf_d = res_q[LST][MSB];
            of_d = ovf_q[LST];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign zf = zf_q;
    assign sf = sf_q;
    assign of = of_q;
endmodule

// File: tb/tb_alu_pipe_cc.sv
// tb/tb_alu_pipe_cc.sv - scoreboard testbench for alu_pipe_cc at LATENCY 2 with 1 and 4 companions
module tb_alu_pipe_cc;
    localparam int W = 64;
    localparam int L = 2;
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] r;
        logic         o;
        logic         s;
        logic [31:0]  c;
    } item_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   ctrl;
    logic [W-1:0] a, b;
    logic         set_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         zf, sf, of;

    logic         xin_valid;
    logic         xrdy [2];
    logic         xval [2];
    logic [W-1:0] xres [2];
    logic         xovf [2];
    logic         xzf [2];
    logic         xsf [2];
    logic         xof [2];
    int           xlat [2] = '{1, 4};

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           strict_lat;
    logic         mzf = 1'b1, msf = 1'b0, mof = 1'b0;
    item_t        sb[$];
    item_t        xq0[$];
    item_t        xq1[$];
    bit           presented = 0;
    bit           held = 0;
    logic [W:0]   held_val;

    always #5 clk = ~clk;

    assign xin_valid = in_valid && in_ready;

    alu_pipe_cc #(.WIDTH(W), .LATENCY(L)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
        .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .zf(zf), .sf(sf), .of(of)
    );

    alu_pipe_cc #(.WIDTH(W), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(xin_valid), .in_ready(xrdy[0]), .ctrl(ctrl),
        .a(a), .b(b), .set_cc(set_cc), .out_valid(xval[0]), .out_ready(1'b1),
        .result(xres[0]), .overflow(xovf[0]), .zf(xzf[0]), .sf(xsf[0]), .of(xof[0])
    );

    alu_pipe_cc #(.WIDTH(W), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(xin_valid), .in_ready(xrdy[1]), .ctrl(ctrl),
        .a(a), .b(b), .set_cc(set_cc), .out_valid(xval[1]), .out_ready(1'b1),
        .result(xres[1]), .overflow(xovf[1]), .zf(xzf[1]), .sf(xsf[1]), .of(xof[1])
    );

    function automatic void chk(string nm, logic [W+1:0] act, logic [W+1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: exact signed arithmetic one bit wider; overflow means the true value does not fit.
    function automatic item_t ref_op(logic [1:0] op, logic [W-1:0] x, logic [W-1:0] y, logic s);
        logic signed [W:0] ex, ey, e;
        item_t it;
        ex = $signed({x[W-1], x});
        ey = $signed({y[W-1], y});
        it.s = s;
        it.c = cyc;
        it.o = 1'b0;
        case (op)
            2'd0: begin e = ex + ey; it.r = e[W-1:0]; it.o = (e > $signed({1'b0, MAXP})) || (e < $signed({1'b1, MINN})); end
            2'd1: begin e = ex - ey; it.r = e[W-1:0]; it.o = (e > $signed({1'b0, MAXP})) || (e < $signed({1'b1, MINN})); end
            2'd2: it.r = x & y;
            default: it.r = x ^ y;
        endcase
        return it;
    endfunction

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = MAXP;
            2: v = MINN;
            3: v = '1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        item_t it;
        cyc++;
        if (rst) begin
            sb.delete(); xq0.delete(); xq1.delete();
            presented = 0; held = 0;
            mzf = 1'b1; msf = 1'b0; mof = 1'b0;
        end else begin
            chk("in_ready", in_ready, (sb.size() < L) || out_ready);
            chk("cc", {zf, sf, of}, {mzf, msf, mof});
            if (held) begin
                chk("held_valid", out_valid, 1'b1);
                chk("held_stable", {overflow, result}, held_val);
            end
            held = 0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    if (!presented) begin
                        presented = 1;
                        if (strict_lat) chk("latency", cyc - int'(sb[0].c), L);
                    end
                    if (out_ready) begin
                        it = sb.pop_front();
                        chk("result", result, it.r);
                        chk("overflow", overflow, it.o);
                        if (it.s) begin
                            mzf = (it.r == '0); msf = it.r[W-1]; mof = it.o;
                        end
                        presented = 0;
                    end else begin
                        held = 1;
                        held_val = {overflow, result};
                    end
                end
            end
            if (xval[0]) begin
                if (xq0.size() == 0) chk("l1_spurious", 1'b1, 1'b0);
                else begin
                    it = xq0.pop_front();
                    chk("l1_result", {xovf[0], xres[0]}, {it.o, it.r});
                    chk("l1_latency", cyc - int'(it.c), xlat[0]);
                end
            end
            if (xval[1]) begin
                if (xq1.size() == 0) chk("l4_spurious", 1'b1, 1'b0);
                else begin
                    it = xq1.pop_front();
                    chk("l4_result", {xovf[1], xres[1]}, {it.o, it.r});
                    chk("l4_latency", cyc - int'(it.c), xlat[1]);
                end
            end
            if (in_valid && in_ready) begin
                it = ref_op(ctrl, a, b, set_cc);
                sb.push_back(it);
                xq0.push_back(it);
                xq1.push_back(it);
                if (xrdy[0] !== 1'b1 || xrdy[1] !== 1'b1) chk("x_in_ready", {xrdy[0], xrdy[1]}, 2'b11);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bit acc = 0;
        int n = 0;
        ctrl = op; a = x; b = y; set_cc = s; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("issue_accepted", acc, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || xq0.size() != 0 || xq1.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_done", sb.size() + xq0.size() + xq1.size(), 0);
        chk("l1_cc", {xzf[0], xsf[0], xof[0]}, {mzf, msf, mof});
        chk("l4_cc", {xzf[1], xsf[1], xof[1]}, {mzf, msf, mof});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; ctrl = '0; a = '0; b = '0; set_cc = 1'b0;
        out_ready = 1'b1; strict_lat = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", {overflow, result}, '0);
        chk("rst_cc", {zf, sf, of}, 3'b100);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(2'd0, 64'd7, -64'sd7, 1'b1);
        wait_drain();
        chk("add_zero_cc", {zf, sf, of}, 3'b100);
        issue(2'd0, MAXP, 64'd1, 1'b1);
        wait_drain();
        chk("add_ovf_cc", {zf, sf, of}, 3'b011);
        issue(2'd1, MINN, 64'd1, 1'b0);
        wait_drain();
        chk("sub_nocc_cc", {zf, sf, of}, 3'b011);
        issue(2'd2, 64'hF0F0, 64'h0FF0, 1'b1);
        issue(2'd3, 64'hFF, 64'h0F, 1'b0);
        wait_drain();
        chk("and_cc", {zf, sf, of}, 3'b000);

        strict_lat = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(2'($urandom), rand_val(), rand_val(), 1'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1; out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1; out_ready = 1'b1;
            end
        join
        wait_drain();

        repeat (600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            ctrl      = 2'($urandom);
            a         = rand_val();
            b         = rand_val();
            set_cc    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        strict_lat = 1;
        issue(2'd0, MAXP, 64'd1, 1'b1);
        wait_drain();
        chk("pre_rst_cc", {zf, sf, of}, 3'b011);
        strict_lat = 0;
        out_ready = 1'b0;
        issue(2'd0, 64'd1, 64'd2, 1'b1);
        issue(2'd0, 64'd3, 64'd4, 1'b1);
        #2;
        chk("pre_rst_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_result", {overflow, result}, '0);
        chk("mid_rst_cc", {zf, sf, of}, 3'b100);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        strict_lat = 1;
        issue(2'd1, 64'd10, 64'd3, 1'b1);
        wait_drain();
        chk("post_rst_cc", {zf, sf, of}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
